divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//  Shares the single iterative 4-bit divider between NUM_REQ requesters, e.g. solver, cell-index decoder and display.
//  Picks a requester round-robin, latches its operands and runs the divider's Start/compute/Ack handshake.
//  Returns quotient/remainder to the winner. Blocks divide-by-zero (the divider never terminates on Y=0) and bounds run time.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    4   operand/result width; must match divider
//  TIMEOUT   20  max SCEN-enabled compute cycles before forced abort (>= 2^DATA_W)
// PORTS
//  Clk           in   1            rising-edge clock
//  Reset_n       in   1            asynchronous, active-low reset
//  Req           in   NUM_REQ      level request per requester
//  ReqX          in   DATA_W*NUM_REQ  dividend, requester i at [i*DATA_W +: DATA_W]
//  ReqY          in   DATA_W*NUM_REQ  divisor, same packing
//  Gnt           out  NUM_REQ      one-hot 1-cycle pulse: operands captured
//  RspValid      out  NUM_REQ      one-hot 1-cycle pulse: result for requester i
//  RspQ          out  DATA_W       quotient, valid with RspValid
//  RspR          out  DATA_W       remainder, valid with RspValid
//  RspErr        out  1            with RspValid: divide-by-zero or timeout
//  Scen          in   1            single-step enable, forwarded in BUSY
//  DivStart      out  1            to divider Start
//  DivAck        out  1            to divider Ack
//  DivScen       out  1            to divider SCEN
//  DivX, DivY    out  DATA_W       to divider Xin/Yin (registered)
//  DivDone       in   1            from divider Done
//  DivQ, DivR    in   DATA_W       from divider Quotient/Remainder
// BEHAVIOUR
//  Reset (Reset_n=0, async): state IDLE, rr pointer 0, all outputs 0, DivX/DivY 0, timeout count 0.
//   Top level resets the divider from the same source, inverted to its active-high Reset.
//  FSM: IDLE -> START -> BUSY -> ACK -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: if |Req, grant first requesting index at/after rr pointer (wrapping); pulse Gnt[i].
//   Latch ReqX/ReqY slice into DivX/DivY and latch the index.
//   Next state ERR if ReqY slice == 0, else START. No Req: stay, outputs 0.
//  START (1 cycle): DivStart=1; divider (in INITIAL) loads DivX/DivY and enters COMPUTE at this edge.
//  BUSY: DivScen=Scen; timeout count increments only when Scen=1.
//   DivDone=1 -> ACK with err=0.
//   Count reaches TIMEOUT -> ACK with err=1.
//  ACK (1 cycle): DivAck=1; RspValid[idx]=1.
//   RspQ/RspR = DivQ/DivR when err=0, else 0; RspErr=err.
//   rr pointer = idx+1 mod NUM_REQ; -> IDLE.
//  ERR (1 cycle): RspValid[idx]=1, RspErr=1, RspQ=RspR=0, divider untouched; rr advances; -> IDLE.
//  Latency with Scen held 1: Gnt at cycle 0; RspValid at cycle q+4, where q = X/Y.
//   Divide-by-zero: RspValid at cycle 1.
//  Requester rules: hold ReqX/ReqY stable while Req=1 and Gnt not yet seen. After Gnt, operands and Req are don't-care.
//   A requester wanting another division re-asserts Req after its RspValid; a Req held through RspValid counts as a new request.
//  Req dropped before grant: withdrawn, no response. Req dropped after Gnt: response still delivered.
//  Simultaneous Req: round-robin only. Requester i waits at most NUM_REQ-1 other transactions.
//  Gnt, RspValid and DivStart/DivAck are never asserted outside their states; at most one bit of Gnt/RspValid is high.
//  Timeout abort leaves the divider in COMPUTE. Top level must reset it; RspErr is the trigger (never hit with valid Y).
// STRUCTURE
//  divarb_pkg: state localparams (one-hot, 5 states), DATA_W default, TIMEOUT default.
//  Sub-module rr_arbiter: NUM_REQ-wide combinational round-robin pick (req, ptr -> one-hot grant + index).
//   The rr pointer register stays in divider_arbiter.
//  Remainder of the block is a single FSM plus operand/index/timeout registers.
// TESTING (bench instantiates the real divider)
//  Single req0 X=13,Y=4, Scen=1 -> Gnt[0] cycle 0; RspValid[0] cycle 7, RspQ=3, RspR=1, RspErr=0.
//  Req=4'b1111 held, operands i+8 / 2 -> grants in order 0,1,2,3,0; each RspValid matches its index.
//  req2 Y=0, X=9 -> RspValid[2] one cycle after Gnt, RspErr=1, RspQ=RspR=0; DivStart never pulsed.
//  X=15,Y=1 with Scen toggling every other cycle -> RspQ=15, RspR=0, no timeout; RspValid delayed ~2x.
//  Reset_n low during BUSY -> next cycle outputs all 0, state IDLE; new req1 X=6,Y=3 -> RspQ=2, RspR=0.
//  Scen=0 forever in BUSY -> no RspValid and no timeout; raise Scen -> normal completion.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// divarb_pkg : one-hot FSM states, default sizing and pointer helper
// Revision   : 1.0
// ==========================================================================
package divarb_pkg;

  localparam int c_NUM_REQ = 4;
  localparam int c_DATA_W  = 4;
  localparam int c_TIMEOUT = 20;

  localparam int c_ST_W = 5;
  localparam logic [c_ST_W-1:0] c_ST_IDLE  = 5'b00001;
  localparam logic [c_ST_W-1:0] c_ST_START = 5'b00010;
  localparam logic [c_ST_W-1:0] c_ST_BUSY  = 5'b00100;
  localparam logic [c_ST_W-1:0] c_ST_ACK   = 5'b01000;
  localparam logic [c_ST_W-1:0] c_ST_ERR   = 5'b10000;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_arbiter_if.sv
`default_nettype none
// ==========================================================================
// divider_arbiter_if : requester request/response bus plus divider handshake
// Revision           : 1.0
// ==========================================================================
interface divider_arbiter_if
  import divarb_pkg::*;
#(
  parameter int NUM_REQ = c_NUM_REQ,
  parameter int DATA_W  = c_DATA_W
);

  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*DATA_W-1:0] ReqX;
  logic [NUM_REQ*DATA_W-1:0] ReqY;
  logic [NUM_REQ-1:0]        Gnt;
  logic [NUM_REQ-1:0]        RspValid;
  logic [DATA_W-1:0]         RspQ;
  logic [DATA_W-1:0]         RspR;
  logic                      RspErr;
  logic                      Scen;
  logic                      DivStart;
  logic                      DivAck;
  logic                      DivScen;
  logic [DATA_W-1:0]         DivX;
  logic [DATA_W-1:0]         DivY;
  logic                      DivDone;
  logic [DATA_W-1:0]         DivQ;
  logic [DATA_W-1:0]         DivR;

  modport slave (
    input  Req, ReqX, ReqY, Scen, DivDone, DivQ, DivR,
    output Gnt, RspValid, RspQ, RspR, RspErr,
    output DivStart, DivAck, DivScen, DivX, DivY
  );

  modport master (
    output Req, ReqX, ReqY, Scen, DivDone, DivQ, DivR,
    input  Gnt, RspValid, RspQ, RspR, RspErr,
    input  DivStart, DivAck, DivScen, DivX, DivY
  );

endinterface
`default_nettype wire

// File: rtl/divider_arbiter_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : combinational round-robin pick, first request at/after ptr
// Revision   : 1.0
// ==========================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               hit
);

  logic [IDX_W:0] w_cand;

  // One extra bit lets ptr+k exceed NUM_REQ before the wrap subtract.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    hit    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!hit && req[w_cand[IDX_W-1:0]]) begin
        hit                     = 1'b1;
        idx                     = w_cand[IDX_W-1:0];
        gnt[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ==========================================================================
// divider_arbiter : round-robin sharing of one iterative divider, with
//                   divide-by-zero blocking and a SCEN-cycle timeout
// Revision        : 1.0
// ==========================================================================
module divider_arbiter
  import divarb_pkg::*;
#(
  parameter int NUM_REQ = c_NUM_REQ,
  parameter int DATA_W  = c_DATA_W,
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  divider_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [c_ST_W-1:0]  r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_div_x;
  logic [DATA_W-1:0]  r_div_y;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_hit;
  logic [DATA_W-1:0]  w_sel_x;
  logic [DATA_W-1:0]  w_sel_y;
  logic               w_rsp_active;
  logic               w_ok_result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (bus.Req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .hit (w_pick_hit)
  );

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_x = bus.ReqX[i*DATA_W +: DATA_W];
        w_sel_y = bus.ReqY[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= c_ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_div_x <= '0;
      r_div_y <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_pick_hit) begin
            r_idx   <= w_pick_idx;
            r_div_x <= w_sel_x;
            r_div_y <= w_sel_y;
            r_cnt   <= '0;
            // Y=0 would spin the divider forever, so it never gets started.
            if (w_sel_y == '0) begin
              r_err   <= 1'b1;
              r_state <= c_ST_ERR;
            end else begin
              r_err   <= 1'b0;
              r_state <= c_ST_START;
            end
          end
        end
        c_ST_START: begin
          r_state <= c_ST_BUSY;
        end
        c_ST_BUSY: begin
          if (bus.DivDone) begin
            r_err   <= 1'b0;
            r_state <= c_ST_ACK;
          end else if (bus.Scen) begin
            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_state <= c_ST_ACK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_ST_ACK, c_ST_ERR: begin
          r_ptr   <= IDX_W'(rr_next(int'(r_idx), NUM_REQ));
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign w_rsp_active = (r_state == c_ST_ACK) || (r_state == c_ST_ERR);
  assign w_ok_result  = (r_state == c_ST_ACK) && !r_err;

  assign bus.Gnt      = (r_state == c_ST_IDLE) ? w_pick_gnt : '0;
  assign bus.RspValid = w_rsp_active ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx) : '0;
  assign bus.RspErr   = w_rsp_active & r_err;
  assign bus.RspQ     = w_ok_result ? bus.DivQ : '0;
  assign bus.RspR     = w_ok_result ? bus.DivR : '0;

  assign bus.DivStart = (r_state == c_ST_START);
  assign bus.DivAck   = (r_state == c_ST_ACK);
  assign bus.DivScen  = (r_state == c_ST_BUSY) & bus.Scen;
  assign bus.DivX     = r_div_x;
  assign bus.DivY     = r_div_y;

  a_gnt_onehot : assert property (@(posedge Clk) disable iff (!Reset_n) $onehot0(bus.Gnt));
  a_rsp_onehot : assert property (@(posedge Clk) disable iff (!Reset_n) $onehot0(bus.RspValid));
  a_start_ack  : assert property (@(posedge Clk) disable iff (!Reset_n) !(bus.DivStart && bus.DivAck));

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// Bench for divider_arbiter: behavioural divider in the loop, randomized traffic
// checked against a round-robin / X/Y / latency reference model.
module tb_divider_arbiter;
  import divarb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int TO = 20;

  typedef struct {
    int idx;
    int cyc;
    int q;
    int r;
    int err;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divider_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  divider_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cnt = 0;
  ev_t gnt_q[$];
  ev_t rsp_q[$];

  logic scen_level;
  logic scen_mode;
  logic scen_tog = 1'b0;
  bit   div_stall;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) scen_tog <= ~scen_tog;
  assign bus.Scen = scen_mode ? scen_tog : scen_level;

  // Behavioural iterative divider: INITIAL -> COMPUTE (one subtract per SCEN) -> DONE.
  localparam logic [1:0] D_INIT = 2'd0;
  localparam logic [1:0] D_COMP = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;
  logic [1:0]    d_state;
  logic [DW-1:0] d_x, d_y, d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= D_INIT;
      d_x <= '0;
      d_y <= '0;
      d_q <= '0;
    end else if ((|bus.RspValid) && bus.RspErr) begin
      d_state <= D_INIT;
    end else begin
      case (d_state)
        D_INIT: if (bus.DivStart) begin
          d_x <= bus.DivX;
          d_y <= bus.DivY;
          d_q <= '0;
          d_state <= D_COMP;
        end
        D_COMP: if (bus.DivScen && !div_stall) begin
          if (d_x >= d_y) begin
            d_x <= d_x - d_y;
            d_q <= d_q + 1'b1;
          end else begin
            d_state <= D_DONE;
          end
        end
        D_DONE: if (bus.DivAck) d_state <= D_INIT;
        default: d_state <= D_INIT;
      endcase
    end
  end

  assign bus.DivDone = (d_state == D_DONE);
  assign bus.DivQ    = d_q;
  assign bus.DivR    = d_x;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(bus.Gnt) || !$onehot0(bus.RspValid)) begin
        failures++;
        $display("FAIL onehot gnt=%b rsp=%b required at most one bit each", bus.Gnt, bus.RspValid);
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.Gnt[i]) gnt_q.push_back('{i, cyc, 0, 0, 0});
        if (bus.RspValid[i]) rsp_q.push_back('{i, cyc, int'(bus.RspQ), int'(bus.RspR), int'(bus.RspErr)});
      end
      if (bus.DivStart) start_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic int exp_q(input int x, input int y);
    return (y == 0) ? 0 : x / y;
  endfunction

  function automatic int exp_r(input int x, input int y);
    return (y == 0) ? 0 : x % y;
  endfunction

  function automatic int exp_lat(input int x, input int y);
    return (y == 0) ? 1 : x / y + 4;
  endfunction

  function automatic logic [27:0] out_vec();
    return {bus.Gnt, bus.RspValid, bus.RspQ, bus.RspR, bus.RspErr,
            bus.DivStart, bus.DivAck, bus.DivScen, bus.DivX, bus.DivY};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int x, input int y);
    bus.ReqX[i*DW +: DW] = DW'(x);
    bus.ReqY[i*DW +: DW] = DW'(y);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.Req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    gnt_q.delete();
    rsp_q.delete();
  endtask

  task automatic issue_grant(input logic [NR-1:0] mask, output bit got, output int c0);
    gnt_q.delete();
    rsp_q.delete();
    c0      = cyc;
    bus.Req = mask;
    got     = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      tick();
      got = (gnt_q.size() > 0);
    end
    bus.Req = '0;
  endtask

  task automatic wait_rsp(input int bound, output bit got);
    got = (rsp_q.size() > 0);
    for (int n = 0; n < bound && !got; n++) begin
      tick();
      got = (rsp_q.size() > 0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (out_vec() !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", out_vec());
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (out_vec() !== 28'h0) begin
      failures++;
      $display("FAIL idle_outputs got=%h required=0", out_vec());
    end
    tick();
  endtask

  task automatic test_single();
    bit gg, gr;
    int c0;
    set_ops(0, 13, 4);
    issue_grant(4'b0001, gg, c0);
    wait_rsp(60, gr);
    checks++;
    if (!gg || !gr) begin
      failures++;
      $display("FAIL single_timeout gnt_seen=%0d rsp_seen=%0d required 1 1", gg, gr);
    end else begin
      checks++;
      if (gnt_q[0].idx != 0 || gnt_q[0].cyc != c0) begin
        failures++;
        $display("FAIL single_gnt idx=%0d cyc=%0d required idx=0 cyc=%0d", gnt_q[0].idx, gnt_q[0].cyc, c0);
      end
      checks++;
      if (rsp_q[0].idx != 0 || rsp_q[0].cyc - c0 != 7) begin
        failures++;
        $display("FAIL single_rsp idx=%0d lat=%0d required idx=0 lat=7", rsp_q[0].idx, rsp_q[0].cyc - c0);
      end
      checks++;
      if (rsp_q[0].q != 3 || rsp_q[0].r != 1 || rsp_q[0].err != 0) begin
        failures++;
        $display("FAIL single_result q=%0d r=%0d err=%0d required 3 1 0", rsp_q[0].q, rsp_q[0].r, rsp_q[0].err);
      end
    end
  endtask

  task automatic test_round_robin();
    bit done;
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, i + 8, 2);
    bus.Req = 4'b1111;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      done = (gnt_q.size() >= 5);
    end
    bus.Req = '0;
    for (int n = 0; n < 60 && rsp_q.size() < 5; n++) tick();
    checks++;
    if (gnt_q.size() < 5 || rsp_q.size() < 5) begin
      failures++;
      $display("FAIL rr_count gnts=%0d rsps=%0d required 5 5", gnt_q.size(), rsp_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gnt_q[k].idx != k % NR || rsp_q[k].idx != k % NR) begin
          failures++;
          $display("FAIL rr_order k=%0d gnt=%0d rsp=%0d required %0d", k, gnt_q[k].idx, rsp_q[k].idx, k % NR);
        end
        checks++;
        if (rsp_q[k].q != (k % NR + 8) / 2 || rsp_q[k].r != (k % NR + 8) % 2 || rsp_q[k].err != 0) begin
          failures++;
          $display("FAIL rr_result k=%0d q=%0d r=%0d err=%0d required %0d %0d 0", k, rsp_q[k].q,
                   rsp_q[k].r, rsp_q[k].err, (k % NR + 8) / 2, (k % NR + 8) % 2);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_div_zero();
    bit gg, gr;
    int c0, s0;
    s0 = start_cnt;
    set_ops(2, 9, 0);
    issue_grant(4'b0100, gg, c0);
    wait_rsp(20, gr);
    tick();
    checks++;
    if (!gg || !gr) begin
      failures++;
      $display("FAIL dz_timeout gnt_seen=%0d rsp_seen=%0d required 1 1", gg, gr);
    end else begin
      checks++;
      if (rsp_q[0].idx != 2 || rsp_q[0].cyc - c0 != 1) begin
        failures++;
        $display("FAIL dz_rsp idx=%0d lat=%0d required idx=2 lat=1", rsp_q[0].idx, rsp_q[0].cyc - c0);
      end
      checks++;
      if (rsp_q[0].err != 1 || rsp_q[0].q != 0 || rsp_q[0].r != 0) begin
        failures++;
        $display("FAIL dz_result q=%0d r=%0d err=%0d required 0 0 1", rsp_q[0].q, rsp_q[0].r, rsp_q[0].err);
      end
      checks++;
      if (start_cnt != s0) begin
        failures++;
        $display("FAIL dz_divstart pulses=%0d required 0", start_cnt - s0);
      end
    end
  endtask

  task automatic test_random();
    int xs[NR];
    int ys[NR];
    logic [NR-1:0] m;
    int p, w, c0;
    bit gg, gr;
    do_reset();
    p = 0;
    for (int it = 0; it < 24; it++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        xs[i] = int'($urandom_range(0, 15));
        ys[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
        set_ops(i, xs[i], ys[i]);
      end
      w = rr_pick(m, p);
      issue_grant(m, gg, c0);
      wait_rsp(60, gr);
      repeat (2) tick();
      checks++;
      if (!gg || !gr) begin
        failures++;
        $display("FAIL rand_timeout it=%0d gnt_seen=%0d rsp_seen=%0d required 1 1", it, gg, gr);
      end else begin
        checks++;
        if (gnt_q[0].idx != w || rsp_q.size() != 1 || rsp_q[0].idx != w) begin
          failures++;
          $display("FAIL rand_pick it=%0d mask=%b gnt=%0d rsp=%0d nrsp=%0d required %0d", it, m,
                   gnt_q[0].idx, rsp_q[0].idx, rsp_q.size(), w);
        end
        checks++;
        if (rsp_q[0].q != exp_q(xs[w], ys[w]) || rsp_q[0].r != exp_r(xs[w], ys[w]) ||
            rsp_q[0].err != int'(ys[w] == 0)) begin
          failures++;
          $display("FAIL rand_result it=%0d x=%0d y=%0d q=%0d r=%0d err=%0d required %0d %0d %0d", it,
                   xs[w], ys[w], rsp_q[0].q, rsp_q[0].r, rsp_q[0].err, exp_q(xs[w], ys[w]),
                   exp_r(xs[w], ys[w]), int'(ys[w] == 0));
        end
        checks++;
        if (rsp_q[0].cyc - c0 != exp_lat(xs[w], ys[w])) begin
          failures++;
          $display("FAIL rand_latency it=%0d lat=%0d required %0d", it, rsp_q[0].cyc - c0, exp_lat(xs[w], ys[w]));
        end
      end
      p = (w + 1) % NR;
    end
  endtask

  task automatic test_scen_toggle();
    bit gg, gr;
    int c0, lat;
    set_ops(3, 15, 1);
    scen_mode = 1'b1;
    issue_grant(4'b1000, gg, c0);
    wait_rsp(100, gr);
    scen_mode = 1'b0;
    checks++;
    if (!gg || !gr) begin
      failures++;
      $display("FAIL toggle_timeout gnt_seen=%0d rsp_seen=%0d required 1 1", gg, gr);
    end else begin
      lat = rsp_q[0].cyc - c0;
      checks++;
      if (rsp_q[0].q != 15 || rsp_q[0].r != 0 || rsp_q[0].err != 0) begin
        failures++;
        $display("FAIL toggle_result q=%0d r=%0d err=%0d required 15 0 0", rsp_q[0].q, rsp_q[0].r, rsp_q[0].err);
      end
      checks++;
      if (lat < 20 || lat > 40) begin
        failures++;
        $display("FAIL toggle_latency lat=%0d required 20..40", lat);
      end
    end
    tick();
  endtask

  task automatic test_scen_stall();
    bit gg, gr;
    int c0;
    set_ops(1, 7, 2);
    scen_level = 1'b0;
    issue_grant(4'b0010, gg, c0);
    repeat (60) tick();
    checks++;
    if (!gg || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_hold gnt_seen=%0d rsps=%0d required 1 0", gg, rsp_q.size());
    end
    scen_level = 1'b1;
    wait_rsp(40, gr);
    checks++;
    if (!gr) begin
      failures++;
      $display("FAIL stall_resume rsp_seen=0 required 1");
    end else begin
      checks++;
      if (rsp_q[0].idx != 1 || rsp_q[0].q != 3 || rsp_q[0].r != 1 || rsp_q[0].err != 0) begin
        failures++;
        $display("FAIL stall_result idx=%0d q=%0d r=%0d err=%0d required 1 3 1 0", rsp_q[0].idx,
                 rsp_q[0].q, rsp_q[0].r, rsp_q[0].err);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    bit gg, gr;
    int c0;
    div_stall = 1'b1;
    set_ops(0, 5, 1);
    issue_grant(4'b0001, gg, c0);
    wait_rsp(80, gr);
    div_stall = 1'b0;
    checks++;
    if (!gg || !gr) begin
      failures++;
      $display("FAIL tmo_wait gnt_seen=%0d rsp_seen=%0d required 1 1", gg, gr);
    end else begin
      checks++;
      if (rsp_q[0].cyc - c0 != TO + 2 || rsp_q[0].err != 1 || rsp_q[0].q != 0 || rsp_q[0].r != 0) begin
        failures++;
        $display("FAIL tmo_rsp lat=%0d err=%0d q=%0d r=%0d required lat=%0d err=1 q=0 r=0",
                 rsp_q[0].cyc - c0, rsp_q[0].err, rsp_q[0].q, rsp_q[0].r, TO + 2);
      end
    end
    tick();
    set_ops(0, 14, 3);
    issue_grant(4'b0001, gg, c0);
    wait_rsp(60, gr);
    checks++;
    if (!gr || rsp_q[0].q != 4 || rsp_q[0].r != 2 || rsp_q[0].err != 0 || rsp_q[0].cyc - c0 != 8) begin
      failures++;
      $display("FAIL tmo_recover seen=%0d q=%0d r=%0d err=%0d required 4 2 0 lat 8", gr,
               gr ? rsp_q[0].q : -1, gr ? rsp_q[0].r : -1, gr ? rsp_q[0].err : -1);
    end
    tick();
  endtask

  task automatic test_reset_busy();
    bit gg, gr;
    int c0;
    set_ops(1, 15, 1);
    issue_grant(4'b0010, gg, c0);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() !== 28'h0) begin
      failures++;
      $display("FAIL rstbusy_outputs got=%h required=0", out_vec());
    end
    tick();
    rst_n = 1'b1;
    tick();
    set_ops(1, 6, 3);
    issue_grant(4'b0010, gg, c0);
    wait_rsp(40, gr);
    repeat (2) tick();
    checks++;
    if (!gg || !gr || gnt_q[0].cyc != c0 || gnt_q[0].idx != 1) begin
      failures++;
      $display("FAIL rstbusy_gnt gnt_seen=%0d rsp_seen=%0d required immediate grant of 1", gg, gr);
    end else begin
      checks++;
      if (rsp_q.size() != 1 || rsp_q[0].idx != 1 || rsp_q[0].q != 2 || rsp_q[0].r != 0 ||
          rsp_q[0].err != 0 || rsp_q[0].cyc - c0 != 6) begin
        failures++;
        $display("FAIL rstbusy_result n=%0d idx=%0d q=%0d r=%0d err=%0d lat=%0d required 1 1 2 0 0 6",
                 rsp_q.size(), rsp_q[0].idx, rsp_q[0].q, rsp_q[0].r, rsp_q[0].err, rsp_q[0].cyc - c0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.Req    = '0;
    bus.ReqX   = '0;
    bus.ReqY   = '0;
    scen_level = 1'b1;
    scen_mode  = 1'b0;
    div_stall  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_random();
    test_scen_toggle();
    test_scen_stall();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
